wptr_rlevel_mon: RTL and testbench
==================================

// Module: wptr_rlevel_mon
// PURPOSE
//  Write-domain consumer of the read-side Gray pointer: synchronizes rptr into wclk, decodes Gray to binary,
//  computes FIFO occupancy against the local binary write pointer, and drives almost-full, high-water-mark,
//  overflow and pointer-integrity status. Sits beside the write-pointer/full logic in the async FIFO;
//  its wq2_rptr output feeds the full comparator.
// PARAMETERS
//  ADDRSIZE     4  FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits (MSB = wrap bit)
//  SYNC_STAGES  2  flops in rptr synchronizer chain; legal range 2..4
// PORTS
//  wclk          in   1           write clock
//  wrst_n        in   1           reset, asynchronous, active-low
//  rptr          in   ADDRSIZE+1  Gray read pointer from rclk domain (asynchronous to wclk)
//  wbin          in   ADDRSIZE+1  registered binary write pointer (wclk domain)
//  winc          in   1           write request this cycle
//  wfull         in   1           registered full flag from write-pointer logic
//  af_thresh     in   ADDRSIZE+1  almost-full threshold, unsigned, sampled every cycle
//  stat_clr      in   1           one-cycle pulse: clear whwm/wovf/wptr_err
//  wq2_rptr      out  ADDRSIZE+1  synchronized Gray read pointer (last sync stage)
//  wrbin         out  ADDRSIZE+1  binary read pointer decoded from wq2_rptr
//  wlevel        out  ADDRSIZE+1  occupancy, 0..2**ADDRSIZE
//  walmost_full  out  1           wlevel >= af_thresh
//  whwm          out  ADDRSIZE+1  high-water mark of wlevel since reset/clear
//  wovf          out  1           sticky: write attempted while full
//  wptr_err      out  1           sticky: illegal synchronized pointer behaviour
// BEHAVIOUR
//  - Reset (wrst_n=0, async): every sync flop and all outputs = 0; deassertion takes effect next wclk edge.
//  - Sync: SYNC_STAGES flop chain on rptr; wq2_rptr = last stage. No logic between stages.
//  - Decode: wrbin registered; wrbin[i] = ^wq2_rptr[ADDRSIZE:i]. Latency 1 cycle after wq2_rptr.
//  - Level: lvl_nxt = (wbin - wrbin) mod 2**(ADDRSIZE+1), both operands the current registered values;
//    wlevel <= lvl_nxt. Total rptr->wlevel latency SYNC_STAGES+2 edges. Level is pessimistic (read lags).
//  - Almost-full: walmost_full <= (lvl_nxt >= af_thresh), unsigned, same edge as wlevel.
//    af_thresh=0 -> 1 from first post-reset edge; af_thresh>2**ADDRSIZE -> never asserts.
//  - HWM: stat_clr=1 -> whwm <= lvl_nxt; else if lvl_nxt > whwm -> whwm <= lvl_nxt; else hold.
//  - Overflow: set_ovf = winc & wfull. wovf <= set_ovf | (wovf & ~stat_clr). Set wins over same-cycle clear.
//  - Pointer check: keep prev copy of wq2_rptr (reset 0). set_err when either:
//    (a) popcount(wq2_rptr ^ prev) > 1 (non-Gray step), or (b) lvl_nxt > 2**ADDRSIZE.
//    wptr_err <= set_err | (wptr_err & ~stat_clr); set wins over clear.
//  - Wrap: wrap bit of wbin/wrbin differs when write has lapped read; modulo subtraction yields correct
//    level, incl. exactly 2**ADDRSIZE (full) with equal low bits and differing MSB.
//  - Level never exceeds 2**ADDRSIZE in legal operation; error path flags but does not saturate wlevel.
//  - Outputs are registered; no combinational path from any input to any output.
//  - Mid-operation reset: all state returns to 0 immediately; no history retained.
// TESTING
//  1 Reset: ADDRSIZE=4, hold wrst_n=0 with rptr=5'h1F, wbin=5'h07 -> all outputs 0; after release,
//    wq2_rptr=5'h1F at edge 2, wrbin=5'h15 at edge 3, wlevel=5'h12 flagged wptr_err at edge 4.
//  2 Fill: rptr=0, wbin stepped 0..16 -> wlevel tracks wbin 1 cycle later, reaches 16; af_thresh=14
//    -> walmost_full rises with wlevel=14; whwm=16.
//  3 Wrap: wbin=5'h12 (bin), rptr=Gray(5'h03)=5'h02 -> wrbin=5'h03, wlevel=15; then wbin=5'h03,
//    rptr=Gray(5'h13)=5'h1A -> wlevel=16 (full across wrap), no wptr_err.
//  4 Overflow: wfull=1, winc=1 one cycle -> wovf=1 next edge, stays 1; stat_clr with winc=0 -> 0;
//    stat_clr and winc&wfull same cycle -> wovf stays 1.
//  5 Integrity: wq2_rptr steps 5'h00 -> 5'h03 (2 bits) -> wptr_err=1 next edge; stat_clr -> 0.
//  6 HWM clear: whwm=12, wlevel drops to 4, pulse stat_clr -> whwm=4; later level 6 -> whwm=6.

Source files
------------

// File: rtl/wptr_rlevel_mon_if.sv
// Purpose: bundles the read-pointer monitor's inputs and status outputs into one port.
// Latency: none, wiring only.
// Backpressure: none; every signal is a level sampled or driven each wclk cycle.
//
// Signals (widths in terms of ADDRSIZE, pointers are ADDRSIZE+1 bits with the MSB as wrap bit):
//   rptr_i         Gray read pointer from the rclk domain (asynchronous)
//   wbin_i         registered binary write pointer
//   winc_i         write request this cycle
//   wfull_i        registered full flag
//   af_thresh_i    almost-full threshold (unsigned)
//   stat_clr_i     one-cycle clear of the sticky/HWM status
//   wq2_rptr_o     synchronized Gray read pointer
//   wrbin_o        decoded binary read pointer
//   wlevel_o       occupancy
//   walmost_full_o occupancy >= threshold
//   whwm_o         high-water mark of occupancy
//   wovf_o         sticky write-while-full
//   wptr_err_o     sticky pointer integrity error
interface wptr_rlevel_mon_if #(
    parameter int ADDRSIZE = 4
);
    logic [ADDRSIZE:0] rptr_i;
    logic [ADDRSIZE:0] wbin_i;
    logic              winc_i;
    logic              wfull_i;
    logic [ADDRSIZE:0] af_thresh_i;
    logic              stat_clr_i;
    logic [ADDRSIZE:0] wq2_rptr_o;
    logic [ADDRSIZE:0] wrbin_o;
    logic [ADDRSIZE:0] wlevel_o;
    logic              walmost_full_o;
    logic [ADDRSIZE:0] whwm_o;
    logic              wovf_o;
    logic              wptr_err_o;

    // Monitor side
    modport slave (
        input  rptr_i, wbin_i, winc_i, wfull_i, af_thresh_i, stat_clr_i,
        output wq2_rptr_o, wrbin_o, wlevel_o, walmost_full_o, whwm_o, wovf_o, wptr_err_o
    );

    // Write-pointer logic / status consumer side
    modport master (
        output rptr_i, wbin_i, winc_i, wfull_i, af_thresh_i, stat_clr_i,
        input  wq2_rptr_o, wrbin_o, wlevel_o, walmost_full_o, whwm_o, wovf_o, wptr_err_o
    );
endinterface

// File: rtl/wptr_rlevel_mon.sv
// Purpose: write-domain monitor of the async FIFO read pointer: sync, Gray decode, level and status.
// Latency: rptr -> wq2_rptr SYNC_STAGES edges, -> wrbin +1, -> wlevel/flags +1 (SYNC_STAGES+2 total).
// Backpressure: none; purely observational, never stalls the write side.
//
// Ports:
//   wclk     write clock
//   wrst_n   asynchronous active-low reset, clears every flop including the synchronizer
//   bus_if   slave modport of wptr_rlevel_mon_if (pointers, write controls, status outputs)
// SYNC_STAGES is meaningful in the range 2..4.
module wptr_rlevel_mon #(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    wptr_rlevel_mon_if.slave     bus_if
);

    // Full FIFO occupancy: only the wrap bit set.
    localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

    logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
    logic [ADDRSIZE:0] wq2_rptr;
    logic [ADDRSIZE:0] prev_q;
    logic [ADDRSIZE:0] wrbin_q,  wrbin_d;
    logic [ADDRSIZE:0] wlevel_q, lvl_nxt;
    logic [ADDRSIZE:0] whwm_q,   whwm_d;
    logic              walmost_full_q, walmost_full_d;
    logic              wovf_q,   wovf_d;
    logic              wptr_err_q, wptr_err_d;
    logic              set_ovf;
    logic              set_err;

    assign wq2_rptr = sync_q[SYNC_STAGES-1];

    // Plain flop chain; nothing combinational between stages so each stage
    // gets a full cycle to resolve metastability.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus_if.rptr_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Gray -> binary: bit i is the XOR of all Gray bits at or above i.
    // Shifting right zero-fills, so reducing the shifted word gives exactly that.
    always_comb begin
        wrbin_d = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wrbin_d[i] = ^(wq2_rptr >> i);
        end
    end

    // Modulo subtraction handles the wrap bit naturally, including the
    // exactly-full case (same low bits, different MSB).
    assign lvl_nxt = bus_if.wbin_i - wrbin_q;

    assign set_ovf = bus_if.winc_i & bus_if.wfull_i;

    // A legal synchronized Gray pointer moves at most one bit per cycle,
    // and the level can never exceed the FIFO depth.
    assign set_err = ($countones(wq2_rptr ^ prev_q) > 1) || (lvl_nxt > DEPTH);

    always_comb begin
        walmost_full_d = (lvl_nxt >= bus_if.af_thresh_i);
        whwm_d         = whwm_q;
        if (bus_if.stat_clr_i || (lvl_nxt > whwm_q)) begin
            // Clear restarts the mark from the current level rather than zero.
            whwm_d = lvl_nxt;
        end
        // Set takes priority over a same-cycle clear so no event is lost.
        wovf_d     = set_ovf | (wovf_q & ~bus_if.stat_clr_i);
        wptr_err_d = set_err | (wptr_err_q & ~bus_if.stat_clr_i);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            prev_q         <= '0;
            wrbin_q        <= '0;
            wlevel_q       <= '0;
            walmost_full_q <= 1'b0;
            whwm_q         <= '0;
            wovf_q         <= 1'b0;
            wptr_err_q     <= 1'b0;
        end else begin
            prev_q         <= wq2_rptr;
            wrbin_q        <= wrbin_d;
            wlevel_q       <= lvl_nxt;
            walmost_full_q <= walmost_full_d;
            whwm_q         <= whwm_d;
            wovf_q         <= wovf_d;
            wptr_err_q     <= wptr_err_d;
        end
    end

    assign bus_if.wq2_rptr_o     = wq2_rptr;
    assign bus_if.wrbin_o        = wrbin_q;
    assign bus_if.wlevel_o       = wlevel_q;
    assign bus_if.walmost_full_o = walmost_full_q;
    assign bus_if.whwm_o         = whwm_q;
    assign bus_if.wovf_o         = wovf_q;
    assign bus_if.wptr_err_o     = wptr_err_q;

endmodule

// File: tb/tb_wptr_rlevel_mon.sv
// Purpose: self-checking bench for wptr_rlevel_mon (directed table, corner sequences, random vs model).
// Latency: checks outputs 1 time unit after each rising wclk edge.
// Backpressure: not applicable.
module tb_wptr_rlevel_mon;

    localparam int AW = 4;
    localparam int S  = 2;

    logic wclk;
    logic wrst_n;

    wptr_rlevel_mon_if #(.ADDRSIZE(AW)) bus ();

    wptr_rlevel_mon #(.ADDRSIZE(AW), .SYNC_STAGES(S)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus_if (bus)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [4:0] wq2;
        logic [4:0] wrbin;
        logic [4:0] lvl;
        logic       af;
        logic [4:0] hwm;
        logic       ovf;
        logic       err;
    } out_t;

    // ---------------- behavioural reference model ----------------
    // rq[0] is the rptr seen at the latest edge, rq[k] the one k edges earlier.
    logic [4:0] rq [S+1];
    out_t       m;

    function automatic logic [4:0] gray(int k);
        logic [4:0] b;
        b = 5'(k);
        return b ^ (b >> 1);
    endfunction

    // Inverse Gray by search: the binary value whose Gray code matches.
    function automatic logic [4:0] g2b(logic [4:0] g);
        for (int b = 0; b < 32; b++) begin
            if (gray(b) == g) return 5'(b);
        end
        return 5'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= S; i++) rq[i] = 5'd0;
        m = '0;
    endtask

    task automatic model_step();
        logic [4:0] lvl;
        logic       seterr;
        if (!wrst_n) begin
            model_reset();
            return;
        end
        // Level uses the decoded read pointer as registered before this edge.
        lvl    = bus.wbin_i - g2b(rq[S]);
        seterr = ($countones(rq[S-1] ^ rq[S]) > 1) || (lvl > 5'd16);
        m.lvl  = lvl;
        m.af   = (lvl >= bus.af_thresh_i);
        if (bus.stat_clr_i || lvl > m.hwm) m.hwm = lvl;
        m.ovf  = (bus.winc_i & bus.wfull_i) | (m.ovf & ~bus.stat_clr_i);
        m.err  = seterr | (m.err & ~bus.stat_clr_i);
        for (int i = S; i > 0; i--) rq[i] = rq[i-1];
        rq[0]   = bus.rptr_i;
        m.wq2   = rq[S-1];
        m.wrbin = g2b(rq[S]);
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.wq2   = bus.wq2_rptr_o;
        o.wrbin = bus.wrbin_o;
        o.lvl   = bus.wlevel_o;
        o.af    = bus.walmost_full_o;
        o.hwm   = bus.whwm_o;
        o.ovf   = bus.wovf_o;
        o.err   = bus.wptr_err_o;
        return o;
    endfunction

    task automatic compare_model(string tag);
        out_t a;
        a = dut_out();
        n_cmp++;
        if (a !== m) begin
            n_fail++;
            $display("FAIL model[%s] @%0t got wq2=%h wrbin=%h lvl=%h af=%b hwm=%h ovf=%b err=%b expected wq2=%h wrbin=%h lvl=%h af=%b hwm=%h ovf=%b err=%b",
                     tag, $time, a.wq2, a.wrbin, a.lvl, a.af, a.hwm, a.ovf, a.err,
                     m.wq2, m.wrbin, m.lvl, m.af, m.hwm, m.ovf, m.err);
        end
    endtask

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One wclk edge: model follows the edge, DUT sampled 1 unit later.
    task automatic tick(int n = 1, string tag = "seq");
        for (int k = 0; k < n; k++) begin
            @(posedge wclk);
            model_step();
            #1;
            compare_model(tag);
        end
    endtask

    task automatic drive_idle();
        bus.rptr_i      = 5'd0;
        bus.wbin_i      = 5'd0;
        bus.winc_i      = 1'b0;
        bus.wfull_i     = 1'b0;
        bus.af_thresh_i = 5'd31;
        bus.stat_clr_i  = 1'b0;
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        drive_idle();
        tick(2, "rst");
        wrst_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [4:0] rptr;
        logic [4:0] wbin;
        logic [4:0] af;
        int         ticks;
        logic [4:0] exp_wrbin;
        logic [4:0] exp_lvl;
        logic       exp_af;
    } vec_t;

    vec_t tbl[$];

    int wc, rc;

    initial begin
        // Fill with rptr held at 0: level follows wbin one edge later.
        tbl.push_back('{5'h00, 5'd0,  5'd14, 1, 5'h00, 5'd0,  1'b0});
        tbl.push_back('{5'h00, 5'd1,  5'd14, 1, 5'h00, 5'd1,  1'b0});
        tbl.push_back('{5'h00, 5'd2,  5'd14, 1, 5'h00, 5'd2,  1'b0});
        tbl.push_back('{5'h00, 5'd3,  5'd14, 1, 5'h00, 5'd3,  1'b0});
        tbl.push_back('{5'h00, 5'd7,  5'd14, 1, 5'h00, 5'd7,  1'b0});
        tbl.push_back('{5'h00, 5'd8,  5'd14, 1, 5'h00, 5'd8,  1'b0});
        tbl.push_back('{5'h00, 5'd13, 5'd14, 1, 5'h00, 5'd13, 1'b0});
        tbl.push_back('{5'h00, 5'd14, 5'd14, 1, 5'h00, 5'd14, 1'b1});
        tbl.push_back('{5'h00, 5'd15, 5'd14, 1, 5'h00, 5'd15, 1'b1});
        tbl.push_back('{5'h00, 5'd16, 5'd14, 1, 5'h00, 5'd16, 1'b1});
        // Threshold boundaries at full occupancy.
        tbl.push_back('{5'h00, 5'd16, 5'd0,  1, 5'h00, 5'd16, 1'b1});
        tbl.push_back('{5'h00, 5'd16, 5'd16, 1, 5'h00, 5'd16, 1'b1});
        tbl.push_back('{5'h00, 5'd16, 5'd17, 1, 5'h00, 5'd16, 1'b0});
        tbl.push_back('{5'h00, 5'd16, 5'd31, 1, 5'h00, 5'd16, 1'b0});

        // ---- 1: reset with live inputs ----
        drive_idle();
        wrst_n      = 1'b0;
        bus.rptr_i  = 5'h1F;
        bus.wbin_i  = 5'h07;
        #3;
        model_reset();
        compare_model("async_rst");
        tick(2, "rst_hold");
        chk("rst_wq2",   bus.wq2_rptr_o,     0);
        chk("rst_wrbin", bus.wrbin_o,        0);
        chk("rst_lvl",   bus.wlevel_o,       0);
        chk("rst_af",    bus.walmost_full_o, 0);
        chk("rst_hwm",   bus.whwm_o,         0);
        chk("rst_ovf",   bus.wovf_o,         0);
        chk("rst_err",   bus.wptr_err_o,     0);
        wrst_n = 1'b1;
        tick();
        tick();
        chk("rel_wq2_e2",   bus.wq2_rptr_o, 5'h1F);
        tick();
        chk("rel_wrbin_e3", bus.wrbin_o,    5'h15);
        tick();
        chk("rel_lvl_e4",   bus.wlevel_o,   5'h12);
        chk("rel_err_e4",   bus.wptr_err_o, 1);

        // ---- 2: fill / threshold table ----
        do_reset();
        foreach (tbl[i]) begin
            bus.rptr_i      = tbl[i].rptr;
            bus.wbin_i      = tbl[i].wbin;
            bus.af_thresh_i = tbl[i].af;
            tick(tbl[i].ticks, "tbl");
            chk($sformatf("tbl%0d_wrbin", i), bus.wrbin_o,        tbl[i].exp_wrbin);
            chk($sformatf("tbl%0d_lvl", i),   bus.wlevel_o,       tbl[i].exp_lvl);
            chk($sformatf("tbl%0d_af", i),    bus.walmost_full_o, tbl[i].exp_af);
        end
        chk("fill_hwm", bus.whwm_o, 16);
        chk("fill_err", bus.wptr_err_o, 0);

        // ---- 3: wrap ----
        do_reset();
        bus.rptr_i = gray(3);
        bus.wbin_i = 5'h12;
        tick(5, "wrapA");
        bus.stat_clr_i = 1'b1;   // discard the transient from the jump setup
        tick(1, "wrapA");
        bus.stat_clr_i = 1'b0;
        chk("wrapA_wrbin", bus.wrbin_o,    5'h03);
        chk("wrapA_lvl",   bus.wlevel_o,   15);
        chk("wrapA_err",   bus.wptr_err_o, 0);
        for (int j = 1; j <= 16; j++) begin
            bus.rptr_i = gray(3 + j);
            tick(4, "wrapB");
            bus.wbin_i = 5'((8'h12 + j) & 8'h1F);
            tick(1, "wrapB");
        end
        bus.wbin_i = 5'h03;
        tick(1, "wrapC");
        chk("wrap_rptr_gray", bus.wq2_rptr_o, 5'h1A);
        chk("wrap_wrbin",     bus.wrbin_o,    5'h13);
        chk("wrap_lvl_full",  bus.wlevel_o,   16);
        chk("wrap_err",       bus.wptr_err_o, 0);

        // ---- 4: overflow ----
        do_reset();
        bus.wfull_i = 1'b1;
        bus.winc_i  = 1'b1;
        tick();
        bus.winc_i  = 1'b0;
        chk("ovf_set", bus.wovf_o, 1);
        tick(3);
        chk("ovf_sticky", bus.wovf_o, 1);
        bus.stat_clr_i = 1'b1;
        tick();
        bus.stat_clr_i = 1'b0;
        chk("ovf_clr", bus.wovf_o, 0);
        bus.stat_clr_i = 1'b1;
        bus.winc_i     = 1'b1;
        tick();
        bus.stat_clr_i = 1'b0;
        bus.winc_i     = 1'b0;
        chk("ovf_set_beats_clr", bus.wovf_o, 1);
        bus.wfull_i = 1'b0;

        // ---- 5: integrity (two-bit pointer jump) ----
        do_reset();
        bus.wbin_i = 5'd2;
        tick(4);
        chk("int_pre", bus.wptr_err_o, 0);
        bus.rptr_i = 5'h03;
        tick(2);
        chk("int_wq2", bus.wq2_rptr_o, 5'h03);
        chk("int_not_yet", bus.wptr_err_o, 0);
        tick();
        chk("int_err", bus.wptr_err_o, 1);
        bus.stat_clr_i = 1'b1;
        tick();
        bus.stat_clr_i = 1'b0;
        chk("int_clr", bus.wptr_err_o, 0);

        // ---- 6: HWM clear ----
        do_reset();
        bus.wbin_i = 5'd12;
        tick(2);
        chk("hwm12_lvl", bus.wlevel_o, 12);
        chk("hwm12",     bus.whwm_o,   12);
        for (int k = 1; k <= 8; k++) begin
            bus.rptr_i = gray(k);
            tick();
        end
        tick(4);
        chk("hwm_lvl4",  bus.wlevel_o, 4);
        chk("hwm_hold",  bus.whwm_o,   12);
        bus.stat_clr_i = 1'b1;
        tick();
        bus.stat_clr_i = 1'b0;
        chk("hwm_clr",   bus.whwm_o,   4);
        bus.wbin_i = 5'd14;
        tick();
        chk("hwm_lvl6",  bus.wlevel_o, 6);
        chk("hwm_rise6", bus.whwm_o,   6);

        // ---- random traffic vs model ----
        do_reset();
        wc = 0;
        rc = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                // Mid-operation async reset: outputs must clear without an edge.
                wrst_n = 1'b0;
                #1;
                model_reset();
                compare_model("midrst");
                drive_idle();
                wc = 0;
                rc = 0;
                tick(1, "midrst");
                wrst_n = 1'b1;
                continue;
            end
            if ($urandom_range(0, 1) == 1 && ((wc - rc) & 31) < 16) wc = (wc + 1) & 31;
            if ($urandom_range(0, 2) == 0 && rc != wc) rc = (rc + 1) & 31;
            bus.rptr_i      = ($urandom_range(0, 49) == 0) ? 5'($urandom) : gray(rc);
            bus.wbin_i      = 5'(wc);
            bus.winc_i      = 1'($urandom);
            bus.wfull_i     = ($urandom_range(0, 7) == 0);
            bus.stat_clr_i  = ($urandom_range(0, 15) == 0);
            bus.af_thresh_i = 5'($urandom_range(0, 18));
            tick(1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
